switch_share_ctrl: RTL

- Round-robin controller that shares one ON/OFF switch FSM (j sets ON, k sets OFF, out reports state) between NUM_REQ requesters.
- Per owner: pulses the switch ON, grants the owner, enforces a maximum hold time, then drives the switch OFF before serving the next requester.
- Sits between the requester agents and the switch FSM; it is the only driver of the switch j/k inputs.

---
 rtl/switch_share_pkg.sv | 20 ++
 rtl/switch_share_ctrl_rr_pick.sv | 35 +++
 rtl/switch_share_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/switch_share_pkg.sv
// Shared types and width helpers for the switch sharing controller.
package switch_share_pkg;

   // Controller states; the encoding is also visible on the debug output.
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      TURN_ON  = 3'd1,
      GRANTED  = 3'd2,
      TURN_OFF = 3'd3,
      FAULT    = 3'd4
   } state_e;

   localparam int STATE_W = 3;

   // Bits needed to hold values 0..n-1 (never less than one bit).
   function automatic int bits_for(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/switch_share_ctrl_rr_pick.sv
// Combinational round-robin finder: first set request bit at or above
// rr_ptr, wrapping around to bit 0.
module rr_pick
   import switch_share_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = bits_for(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [IDX_W-1:0] cand;

   // Scan from the farthest offset down so the nearest set bit wins last.
   always_comb begin
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         if (int'(rr_ptr) + off >= NUM_REQ) begin
            cand = IDX_W'(int'(rr_ptr) + off - NUM_REQ);
         end else begin
            cand = IDX_W'(int'(rr_ptr) + off);
         end
         if (req[cand]) begin
            idx = cand;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_share_ctrl.sv
// Round-robin owner of a shared ON/OFF switch. Each turn: command the switch
// ON, grant the owner for at most MAX_HOLD cycles, command it OFF, and only
// then pick the next requester.
//
// Handshake: req[i] is a level request; grant[i] is asserted only while the
// switch is confirmed ON and drops on the same edge the controller starts
// turning the switch OFF. sw_j/sw_k are level commands held until sw_out
// reaches the commanded level or WAIT_TIMEOUT expires (sticky fault).
module switch_share_ctrl
   import switch_share_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int MAX_HOLD     = 16,
   parameter int WAIT_TIMEOUT = 8
) (
   input  logic               clk,
   input  logic               areset_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic               sw_j,
   output logic               sw_k,
   input  logic               sw_out,
   input  logic               fault_clr,
   output logic               busy,
   output logic               fault,
   output logic [STATE_W-1:0] state_dbg
);

   localparam int IDX_W  = bits_for(NUM_REQ);
   localparam int HOLD_W = bits_for(MAX_HOLD);
   localparam int WAIT_W = bits_for(WAIT_TIMEOUT + 1);

   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(MAX_HOLD - 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_TIMEOUT);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_REQ - 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic               owner_valid_q, owner_valid_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               sw_j_q, sw_j_d;
   logic               sw_k_q, sw_k_d;
   logic               busy_q, busy_d;
   logic               fault_q, fault_d;

   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic               owner_req;
   logic [WAIT_W-1:0]  wait_cnt_inc;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   assign owner_req    = req[owner_q];
   assign wait_cnt_inc = wait_cnt_q + WAIT_W'(1);

   // Next-state logic: owner selection, hold/wait counting, pointer update.
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      owner_valid_d = owner_valid_q;
      rr_ptr_d      = rr_ptr_q;
      hold_cnt_d    = hold_cnt_q;
      wait_cnt_d    = wait_cnt_q;
      case (state_q)
         IDLE: begin
            // A switch found ON with nobody owning it is shut off first.
            if (sw_out) begin
               state_d       = TURN_OFF;
               owner_valid_d = 1'b0;
               wait_cnt_d    = '0;
            end else if (pick_any) begin
               state_d       = TURN_ON;
               owner_d       = pick_idx;
               owner_valid_d = 1'b1;
               wait_cnt_d    = '0;
            end
         end
         TURN_ON: begin
            // A dropped request only matters once the switch is ON.
            if (sw_out) begin
               if (owner_req) begin
                  state_d    = GRANTED;
                  hold_cnt_d = '0;
               end else begin
                  state_d    = TURN_OFF;
                  wait_cnt_d = '0;
               end
            end else if (wait_cnt_inc == WAIT_LIMIT) begin
               state_d = FAULT;
            end else begin
               wait_cnt_d = wait_cnt_inc;
            end
         end
         GRANTED: begin
            if (!sw_out) begin
               state_d = FAULT;
            end else if (!owner_req || hold_cnt_q == HOLD_LAST) begin
               state_d    = TURN_OFF;
               wait_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         TURN_OFF: begin
            if (!sw_out) begin
               state_d = IDLE;
               if (owner_valid_q) begin
                  rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
               end
            end else if (wait_cnt_inc == WAIT_LIMIT) begin
               state_d = FAULT;
            end else begin
               wait_cnt_d = wait_cnt_inc;
            end
         end
         FAULT: begin
            if (fault_clr) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register with it.
   always_comb begin
      grant_d = '0;
      if (state_d == GRANTED) begin
         grant_d[owner_d] = 1'b1;
      end
      sw_j_d  = (state_d == TURN_ON);
      sw_k_d  = (state_d == TURN_OFF);
      busy_d  = (state_d != IDLE);
      fault_d = (state_d == FAULT);
   end

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state_q       <= IDLE;
         owner_q       <= '0;
         owner_valid_q <= 1'b0;
         rr_ptr_q      <= '0;
         hold_cnt_q    <= '0;
         wait_cnt_q    <= '0;
         grant_q       <= '0;
         sw_j_q        <= 1'b0;
         sw_k_q        <= 1'b0;
         busy_q        <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         owner_valid_q <= owner_valid_d;
         rr_ptr_q      <= rr_ptr_d;
         hold_cnt_q    <= hold_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         grant_q       <= grant_d;
         sw_j_q        <= sw_j_d;
         sw_k_q        <= sw_k_d;
         busy_q        <= busy_d;
         fault_q       <= fault_d;
      end
   end

   assign grant     = grant_q;
   assign sw_j      = sw_j_q;
   assign sw_k      = sw_k_q;
   assign busy      = busy_q;
   assign fault     = fault_q;
   assign state_dbg = state_q;

endmodule
